// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the radix-2^k serial divider
`define DIV_RADIX_LEGAL(dw, rb) (((rb) >= 1) && ((dw) >= 2) && (((dw) % (rb)) == 0))

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int iters(input int data_w, input int radix_bits);
    return data_w / radix_bits;
  endfunction

endpackage

// File: rtl/div_serial_radix_if.sv
// rtl/div_serial_radix_if.sv - start/done request and result bundle of the divider
interface div_serial_radix_if #(
  parameter int DATA_W = 32
);
  logic              sign;
  logic              start;
  logic              done;
  logic              busy;
  logic              div_by_zero;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output sign, start, dividend, divisor,
    input  done, busy, quotient, remainder, div_by_zero
  );

  modport slave (
    input  sign, start, dividend, divisor,
    output done, busy, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_radix_step.sv
// rtl/div_radix_step.sv - combinational chain of RADIX_BITS restoring division steps, MSB first
module div_radix_step #(
  parameter int DATA_W     = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic [DATA_W:0]       rem_in,
  input  logic [RADIX_BITS-1:0] bits_in,
  input  logic [DATA_W-1:0]     divisor,
  output logic [DATA_W:0]       rem_out,
  output logic [RADIX_BITS-1:0] q_bits
);

  logic [DATA_W:0] r;
  logic [DATA_W:0] tmp;

  // The running remainder is always below the divisor, so the shift never loses a set bit.
  always_comb begin
    r      = rem_in;
    tmp    = '0;
    q_bits = '0;
    for (int i = RADIX_BITS - 1; i >= 0; i--) begin
      tmp       = (r << 1) | {{DATA_W{1'b0}}, bits_in[i]};
      q_bits[i] = (tmp >= {1'b0, divisor});
      r         = q_bits[i] ? (tmp - {1'b0, divisor}) : tmp;
    end
    rem_out = r;
  end

endmodule

// File: rtl/div_serial_radix.sv
// rtl/div_serial_radix.sv - iterative signed/unsigned divider retiring RADIX_BITS quotient bits per cycle
module div_serial_radix
  import div_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  div_serial_radix_if.slave bus
);

  localparam int N  = iters(DATA_W, RADIX_BITS);
  localparam int CW = $clog2(N) + 1;

  generate
    if (!(`DIV_RADIX_LEGAL(DATA_W, RADIX_BITS))) begin : g_bad_radix
      $error("div_serial_radix: RADIX_BITS must divide DATA_W");
    end
  endgenerate

  state_t            state;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] orig_dvd;
  logic [DATA_W-1:0] work_q;
  logic [DATA_W:0]   work_r;
  logic [CW-1:0]     cnt;
  logic              quot_sign;
  logic              rem_sign;
  logic              dz;
  logic              done_r;
  logic              busy_r;
  logic              dbz_r;
  logic [DATA_W-1:0] quot_r;
  logic [DATA_W-1:0] rem_r;

  logic [DATA_W:0]       next_r;
  logic [RADIX_BITS-1:0] q_bits;
  logic                  neg_dvd;
  logic                  neg_dvs;

  assign neg_dvd = bus.sign & bus.dividend[DATA_W-1];
  assign neg_dvs = bus.sign & bus.divisor[DATA_W-1];

  div_radix_step #(
    .DATA_W    (DATA_W),
    .RADIX_BITS(RADIX_BITS)
  ) u_step (
    .rem_in (work_r),
    .bits_in(dvd[DATA_W-1 -: RADIX_BITS]),
    .divisor(dvs),
    .rem_out(next_r),
    .q_bits (q_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      orig_dvd  <= '0;
      work_q    <= '0;
      work_r    <= '0;
      cnt       <= '0;
      quot_sign <= 1'b0;
      rem_sign  <= 1'b0;
      dz        <= 1'b0;
      done_r    <= 1'b1;
      busy_r    <= 1'b0;
      dbz_r     <= 1'b0;
      quot_r    <= '0;
      rem_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd       <= neg_dvd ? -bus.dividend : bus.dividend;
            dvs       <= neg_dvs ? -bus.divisor : bus.divisor;
            quot_sign <= neg_dvd ^ neg_dvs;
            rem_sign  <= neg_dvd;
            orig_dvd  <= bus.dividend;
            dz        <= (bus.divisor == '0);
            work_q    <= '0;
            work_r    <= '0;
            cnt       <= '0;
            done_r    <= 1'b0;
            busy_r    <= 1'b1;
            state     <= (bus.divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          work_r <= next_r;
          work_q <= (work_q << RADIX_BITS) | DATA_W'(q_bits);
          dvd    <= dvd << RADIX_BITS;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Negation is modulo 2^DATA_W, which makes MIN / -1 come out as MIN with remainder 0.
          if (dz) begin
            quot_r <= '1;
            rem_r  <= orig_dvd;
            dbz_r  <= 1'b1;
          end else begin
            quot_r <= quot_sign ? -work_q : work_q;
            rem_r  <= rem_sign ? -work_r[DATA_W-1:0] : work_r[DATA_W-1:0];
            dbz_r  <= 1'b0;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done        = done_r;
  assign bus.busy        = busy_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;

endmodule

// File: tb/tb_div_serial_radix.sv
// tb/tb_div_serial_radix.sv - scoreboard bench running radix-2 and radix-16 dividers side by side
module tb_div_serial_radix;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_serial_radix_if #(.DATA_W(W)) bus1 ();
  div_serial_radix_if #(.DATA_W(W)) bus4 ();

  div_serial_radix #(.DATA_W(W), .RADIX_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  div_serial_radix #(.DATA_W(W), .RADIX_BITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  exp_t q1[$];
  exp_t q4[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference: plain integer arithmetic; SV signed division truncates and the remainder follows the dividend.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (b == 0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endtask

  task automatic set_ops(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus1.sign = s; bus1.dividend = a; bus1.divisor = b;
    bus4.sign = s; bus4.dividend = a; bus4.divisor = b;
  endtask

  // Returns 1ns after the accepting edge E0.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   guard = 0;
    while (!(bus1.done && !bus1.busy && bus4.done && !bus4.busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      total++;
      $display("FAIL idle_wait: got busy after %0d cycles expected idle", guard);
    end
    model(s, a, b, e.q, e.r, e.dz);
    set_ops(s, a, b);
    bus1.start = 1'b1;
    bus4.start = 1'b1;
    e.lat = e.dz ? 1 : 33;
    q1.push_back(e);
    e.lat = e.dz ? 1 : 9;
    q4.push_back(e);
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done1"}, bus1.done, 1);
    chk({tag, "_busy1"}, bus1.busy, 0);
    chk({tag, "_quot1"}, bus1.quotient, 0);
    chk({tag, "_rem1"},  bus1.remainder, 0);
    chk({tag, "_dz1"},   bus1.div_by_zero, 0);
    chk({tag, "_done4"}, bus4.done, 1);
    chk({tag, "_busy4"}, bus4.busy, 0);
    chk({tag, "_quot4"}, bus4.quotient, 0);
    chk({tag, "_rem4"},  bus4.remainder, 0);
    chk({tag, "_dz4"},   bus4.div_by_zero, 0);
  endtask

  // Monitor: pops an expectation whenever done rises, checking result, latency and hold behaviour.
  logic         prev_done[2];
  int           busy_cnt[2];
  logic         moved[2];
  logic [W-1:0] held_q[2];
  logic [W-1:0] held_r[2];
  logic         held_dz[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_done[d] = 1'b1; busy_cnt[d] = 0; moved[d] = 1'b0;
      held_q[d] = '0; held_r[d] = '0; held_dz[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic         dn, bz, dzv;
        logic [W-1:0] qv, rv;
        exp_t         e;
        string        nm;
        nm = (d == 0) ? "r1" : "r4";
        if (d == 0) begin
          dn = bus1.done; bz = bus1.busy; dzv = bus1.div_by_zero; qv = bus1.quotient; rv = bus1.remainder;
        end else begin
          dn = bus4.done; bz = bus4.busy; dzv = bus4.div_by_zero; qv = bus4.quotient; rv = bus4.remainder;
        end
        if (!rst_n) begin
          prev_done[d] = 1'b1; busy_cnt[d] = 0; moved[d] = 1'b0;
          held_q[d] = '0; held_r[d] = '0; held_dz[d] = 1'b0;
        end else begin
          if (bz) begin
            busy_cnt[d]++;
            if (qv !== held_q[d] || rv !== held_r[d] || dzv !== held_dz[d]) moved[d] = 1'b1;
          end
          if (dn && !prev_done[d]) begin
            if ((d == 0 && q1.size() == 0) || (d == 1 && q4.size() == 0)) begin
              total++;
              $display("FAIL %s_unexpected_done: got completion expected none", nm);
            end else begin
              e = (d == 0) ? q1.pop_front() : q4.pop_front();
              chk({nm, "_quotient"}, qv, e.q);
              chk({nm, "_remainder"}, rv, e.r);
              chk({nm, "_div_by_zero"}, dzv, e.dz);
              chk({nm, "_latency"}, busy_cnt[d], e.lat);
              chk({nm, "_hold_while_busy"}, moved[d], 0);
            end
            held_q[d] = qv; held_r[d] = rv; held_dz[d] = dzv;
            busy_cnt[d] = 0;
            moved[d] = 1'b0;
          end
          prev_done[d] = dn;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    set_ops(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, -32'sd7, 32'd2);
    issue(1'b1, 32'd7, -32'sd2);
    issue(1'b0, 32'hFFFF_FFFF, 32'h10);
    issue(1'b1, 32'h1234, 32'h0);
    issue(1'b0, 32'h1234, 32'h0);
    issue(1'b0, 32'd9, 32'd3);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'hFFFF_FFFF, 32'h1);

    // Stray starts while busy must be ignored.
    issue(1'b0, 32'd50, 32'd5);
    for (int c = 1; c <= 11; c++) begin
      if (c == 3) begin
        set_ops(1'b1, 32'd77, 32'd3);
        bus1.start = 1'b1;
        bus4.start = 1'b1;
      end
      if (c == 10) begin
        bus1.sign = 1'b0; bus1.dividend = 32'd1000; bus1.divisor = 32'd9;
        bus1.start = 1'b1;
      end
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      bus4.start = 1'b0;
    end

    // Asynchronous reset in the middle of a radix-2 run.
    issue(1'b0, 32'd50, 32'd5);
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q1.delete();
    q4.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, 32'd9, 32'd3);

    for (int i = 0; i < 1000; i++) begin
      logic         s;
      logic [W-1:0] a, b;
      int           k;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 15);
      if (k == 0) b = '0;
      else if (k < 5) b = $urandom_range(1, 300);
      else if (k == 5) b = 32'hFFFF_FFFF;
      else if (k == 6) a = 32'h8000_0000;
      else if (k == 7) b = b >> $urandom_range(0, 31);
      issue(s, a, b);
    end

    for (int g = 0; g < 100 && (q1.size() != 0 || q4.size() != 0); g++) @(negedge clk);
    @(negedge clk);
    if (q1.size() != 0 || q4.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q1.size(), q4.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_serial_radix.md
Name: div_serial_radix

Overview:
- Iterative integer divider; successor to the single-bit serial divider.
- Retires RADIX_BITS quotient bits per cycle (radix 2^RADIX_BITS restoring division) and supports signed/unsigned operation per request.
- Corrects the remainder sign (remainder takes the dividend's sign), flags divide-by-zero and reports busy.
- Sits behind the CPU/peripheral MUL/DIV unit; keeps the start/done handshake.

Parameters:
- DATA_W, 32: operand and result width; ≥ 2.
- RADIX_BITS, 1: quotient bits per CALC cycle; must divide DATA_W (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sign  in  1  1 = two's-complement operands; sampled with start.
- start  in  1  request pulse; accepted only when busy=0.
- done  out  1  result valid; high from reset/completion until next accepted start.
- busy  out  1  operation in progress.
- dividend  in  DATA_W  sampled with accepted start.
- divisor  in  DATA_W  sampled with accepted start.
- quotient  out  DATA_W  registered result.
- remainder  out  DATA_W  registered result.
- div_by_zero  out  1  last result came from divisor==0; valid while done=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, done=1, busy=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, CALC, FIX.
- IDLE, start=1 (edge E0):
  - latch |dividend|, |divisor| (abs only if sign=1 and MSB set);
  - latch quot_sign = sign & (dividend MSB ^ divisor MSB), rem_sign = sign & dividend MSB, original dividend, dz = (divisor==0);
  - clear work quotient/remainder and counter; done←0, busy←1;
  - next state CALC, or FIX if dz.
- CALC: each cycle performs RADIX_BITS restoring steps, MSB first:
  - tmp = {rem, next dividend bit}; q bit = tmp ≥ divisor; rem = q ? tmp−divisor : tmp.
  - counter increments; after N = DATA_W/RADIX_BITS cycles → FIX.
- FIX (one cycle), then IDLE with done←1, busy←0:
  - normal: quotient ← quot_sign ? −q : q; remainder ← rem_sign ? −r : r; div_by_zero←0.
  - dz: quotient ← all ones; remainder ← original dividend; div_by_zero←1.
- Latency (start accepted at edge E0):
  - normal: done=1 after edge E0+N+1.
  - divide-by-zero: done=1 after edge E0+1.
- quotient/remainder/div_by_zero change only in FIX. They hold the previous result while busy and stay stable after done until the next completion.
- start while busy=1: ignored, no effect on the current operation.
- start in the same cycle done rises: accepted (state is IDLE).
- Signed overflow MIN/−1: quotient=MIN, remainder=0 (natural result of unsigned |MIN|=2^(DATA_W−1)); no flag.
- Unsigned mode: operands never negated; sign bits ignored.
- Width rules:
  - work remainder is DATA_W+1 bits internally so tmp never overflows;
  - negations are modulo 2^DATA_W;
  - counter width $clog2(N)+1.
- rst_n asserted mid-operation: immediate abort to reset values; no partial result is visible.

Decomposition:
- Package div_pkg: state encoding localparams (IDLE/CALC/FIX); function iters(DATA_W,RADIX_BITS); RADIX_BITS legality check macro.
- Sub-module div_radix_step: combinational RADIX_BITS-deep restoring chain.
  - Inputs: rem, dividend bit slice, divisor.
  - Outputs: new rem, RADIX_BITS quotient bits.
  - Top instantiates it once; FSM, registers and sign fix-up stay in the top.

Test Plan:
- RADIX_BITS=1, DATA_W=32, unsigned 100/7 → quotient=14, remainder=2, div_by_zero=0; done rises after edge E0+33; busy high for exactly 33 cycles.
- Signed −7/2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Signed 7/−2 → quotient=−3, remainder=1.
- RADIX_BITS=4, unsigned 0xFFFFFFFF/0x10 → quotient=0x0FFFFFFF, remainder=0xF; done after edge E0+9. Result matches the RADIX_BITS=1 run on 1000 random signed/unsigned pairs (reference model check).
- Divisor=0, dividend=0x1234 (signed and unsigned) → quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, done after edge E0+1. A following 9/3 clears div_by_zero → quotient=3, remainder=0.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- start pulses with different operands on cycles 3 and 10 of a 50/5 run → still quotient=10, remainder=0. rst_n low at cycle 12 → done=1, busy=0, outputs 0 immediately (async). A new start after release → correct result.
